// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: shared widths, funct3 size codes and FSM encoding for the MEM-stage
// load/store controller.
package lsu_mem_ctrl_pkg;
    localparam int LSU_DATA_WIDTH = 32;
    localparam int LSU_ADDR_WIDTH = 32;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;
    // Signed and unsigned variants share a size; every other code is a word access.
    function automatic size_t decode_size(input logic [2:0] funct3);
        return funct3 inside {F3_LB, F3_LBU} ? SZ_B : funct3 inside {F3_LH, F3_LHU} ? SZ_H : SZ_W;
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane steering for the data-memory port: byte enables, store-data
// replication, misalignment detection and right-alignment of returned load data.
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [1:0]            load_offset,
    input  logic [DATA_WIDTH-1:0] raw_rdata,
    output logic [3:0]            byte_en,
    output logic [DATA_WIDTH-1:0] store_lanes,
    output logic                  misaligned,
    output logic [DATA_WIDTH-1:0] aligned_rdata
);
    size_t size;
    always_comb begin
        size          = decode_size(funct3);
        byte_en       = size == SZ_B ? 4'b0001 << offset : size == SZ_H ? 4'b0011 << offset : 4'b1111;
        store_lanes   = size == SZ_B ? {4{store_data[7:0]}} : size == SZ_H ? {2{store_data[15:0]}} : store_data;
        misaligned    = (size == SZ_H && offset[0]) || (size == SZ_W && offset != 2'b00);
        aligned_rdata = raw_rdata >> {load_offset, 3'b000};
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage req/gnt/rvalid data-memory controller; stalls the pipeline while a
// transaction is outstanding and returns load data right-aligned to bit 0.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_MemRead,
    input  logic                  MEM_MemWrite,
    input  logic [2:0]            MEM_Funct3,
    input  logic [ADDR_WIDTH-1:0] MEM_ALU_Result,
    input  logic [DATA_WIDTH-1:0] MEM_RS2_Data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [DATA_WIDTH-1:0] Mem_R_Data,
    output logic                  Mem_Stall,
    output logic                  Mem_Misaligned
);
    state_t                state;
    logic                  access;
    logic                  misaligned;
    logic [1:0]            load_offset;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] rdata_aligned;

    assign access = MEM_MemRead | MEM_MemWrite;

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3        (MEM_Funct3),
        .offset        (MEM_ALU_Result[1:0]),
        .store_data    (MEM_RS2_Data),
        .load_offset   (load_offset),
        .raw_rdata     (dmem_rdata),
        .byte_en       (be_next),
        .store_lanes   (wdata_next),
        .misaligned    (misaligned),
        .aligned_rdata (rdata_aligned)
    );

    // Stall drops in DONE so the held instruction advances exactly once.
    assign Mem_Misaligned = state == IDLE && access && misaligned;
    assign Mem_Stall      = (state == IDLE && access && !misaligned) || state == REQ || state == WAIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
            load_offset <= 2'b00;
            Mem_R_Data  <= '0;
        end else begin
            case (state)
                IDLE: if (access && !misaligned) begin
                    dmem_req    <= 1'b1;
                    dmem_we     <= MEM_MemWrite;
                    dmem_addr   <= {MEM_ALU_Result[ADDR_WIDTH-1:2], 2'b00};
                    dmem_be     <= be_next;
                    dmem_wdata  <= wdata_next;
                    load_offset <= MEM_ALU_Result[1:0];
                    state       <= REQ;
                end
                REQ: if (dmem_gnt) begin
                    dmem_req <= 1'b0;
                    state    <= dmem_we ? DONE : WAIT;
                end
                WAIT: if (dmem_rvalid) begin
                    Mem_R_Data <= rdata_aligned;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized checks of lsu_mem_ctrl against a byte-level
// reference model with a simple req/gnt/rvalid memory responder.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0;
    logic [2:0]  MEM_Funct3 = 3'b000;
    logic [31:0] MEM_ALU_Result = '0, MEM_RS2_Data = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] Mem_R_Data;
    logic        Mem_Stall, Mem_Misaligned;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_Funct3(MEM_Funct3),
        .MEM_ALU_Result(MEM_ALU_Result), .MEM_RS2_Data(MEM_RS2_Data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .Mem_R_Data(Mem_R_Data), .Mem_Stall(Mem_Stall),
        .Mem_Misaligned(Mem_Misaligned)
    );

    function automatic int size_bytes(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % size_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be;
        int off, n;
        off = addr % 4;
        n = size_bytes(f3);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = size_bytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    // Drives one held MEM-stage instruction and plays memory until the stall drops.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdat,
                           output int stalls, output int reqs, output logic [31:0] o_addr,
                           output logic [31:0] o_wdata, output logic [3:0] o_be, output logic o_we,
                           output logic stable, output logic mis, output logic timeout);
        int req_cyc, wait_cyc;
        logic granted, done, prev_req;
        req_cyc = 0; wait_cyc = 0; granted = 0; done = 0; prev_req = 0;
        stalls = 0; reqs = 0; stable = 1; mis = 0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 0;
        @(posedge clk); #1;
        MEM_MemRead = rd; MEM_MemWrite = wr; MEM_Funct3 = f3;
        MEM_ALU_Result = addr; MEM_RS2_Data = wd;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            dmem_gnt = 0;
            dmem_rvalid = 0;
            if (Mem_Misaligned) mis = 1;
            if (!Mem_Stall) done = 1;
            else stalls++;
            if (dmem_req) begin
                if (granted) stable = 0;
                if (!prev_req) begin
                    reqs++;
                    o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
                end else if (dmem_addr !== o_addr || dmem_wdata !== o_wdata || dmem_be !== o_be || dmem_we !== o_we) begin
                    stable = 0;
                end
                if (req_cyc == gnt_dly) begin
                    dmem_gnt = 1;
                    granted = 1;
                end
                req_cyc++;
            end else if (granted && rd && !wr) begin
                if (wait_cyc == rv_dly) begin
                    dmem_rvalid = 1;
                    dmem_rdata = rdat;
                end
                wait_cyc++;
            end
            prev_req = dmem_req;
        end
        timeout = !done;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        MEM_MemRead = 0;
        MEM_MemWrite = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_dmem: req=%b we=%b be=%b addr=%h wdata=%h, required all zero", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
        end
        checks++;
        if ({Mem_R_Data, Mem_Stall, Mem_Misaligned} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rdata=%h stall=%b mis=%b, required zero", Mem_R_Data, Mem_Stall, Mem_Misaligned);
        end
        rst = 0;
    endtask

    task automatic test_sw_wait();
        int st, rq; logic [31:0] a, w; logic [3:0] be; logic we, stb, mis, to;
        run_txn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 0, 0, st, rq, a, w, be, we, stb, mis, to);
        checks++;
        if (to || st != 4 || rq != 1 || !stb) begin
            failures++;
            $display("FAIL sw_wait_timing: stalls=%0d reqs=%0d stable=%b timeout=%b, required 4/1/1/0", st, rq, stb, to);
        end
        checks++;
        if (a !== 32'h100 || be !== 4'b1111 || w !== 32'hDEADBEEF || we !== 1) begin
            failures++;
            $display("FAIL sw_wait_fields: addr=%h be=%b wdata=%h we=%b, required 100/1111/deadbeef/1", a, be, w, we);
        end
        go_idle();
    endtask

    task automatic test_sb();
        int st, rq; logic [31:0] a, w; logic [3:0] be; logic we, stb, mis, to;
        run_txn(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0, st, rq, a, w, be, we, stb, mis, to);
        checks++;
        if (to || st != 2 || rq != 1) begin
            failures++;
            $display("FAIL sb_timing: stalls=%0d reqs=%0d timeout=%b, required 2/1/0", st, rq, to);
        end
        checks++;
        if (a !== 32'h200 || be !== 4'b1000 || w !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL sb_fields: addr=%h be=%b wdata=%h, required 200/1000/a5a5a5a5", a, be, w);
        end
        go_idle();
    endtask

    task automatic test_lb();
        int st, rq; logic [31:0] a, w, ldu; logic [3:0] be; logic we, stb, mis, to;
        run_txn(1, 0, 3'b000, 32'h302, 32'h0, 0, 0, 32'h11803344, st, rq, a, w, be, we, stb, mis, to);
        exp_rdata = 32'h00001180;
        checks++;
        if (to || st != 3 || rq != 1 || be !== 4'b0100 || a !== 32'h300 || we !== 0) begin
            failures++;
            $display("FAIL lb_txn: stalls=%0d reqs=%0d be=%b addr=%h we=%b, required 3/1/0100/300/0", st, rq, be, a, we);
        end
        ldu = {{24{Mem_R_Data[7]}}, Mem_R_Data[7:0]};
        checks++;
        if (Mem_R_Data !== exp_rdata || ldu !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL lb_data: rdata=%h ext=%h, required %h/ffffff80", Mem_R_Data, ldu, exp_rdata);
        end
        go_idle();
    endtask

    task automatic test_misaligned();
        int st, rq; logic [31:0] a, w, rd; logic [3:0] be; logic we, stb, mis, to;
        run_txn(1, 0, 3'b001, 32'h401, 32'h0, 0, 0, 32'h0, st, rq, a, w, be, we, stb, mis, to);
        checks++;
        if (!mis || st != 0 || rq != 0 || to) begin
            failures++;
            $display("FAIL lh_misaligned: mis=%b stalls=%0d reqs=%0d, required 1/0/0", mis, st, rq);
        end
        rd = $urandom;
        run_txn(1, 0, 3'b010, 32'h404, 32'h0, 0, 0, rd, st, rq, a, w, be, we, stb, mis, to);
        exp_rdata = rd;
        checks++;
        if (mis || st != 3 || rq != 1 || a !== 32'h404 || Mem_R_Data !== exp_rdata) begin
            failures++;
            $display("FAIL lw_after_mis: mis=%b stalls=%0d reqs=%0d addr=%h rdata=%h, required 0/3/1/404/%h", mis, st, rq, a, Mem_R_Data, exp_rdata);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int st, rq; logic [31:0] a, w, rd; logic [3:0] be; logic we, stb, mis, to;
        rd = $urandom;
        run_txn(1, 0, 3'b010, 32'h10, 32'h0, 0, 0, rd, st, rq, a, w, be, we, stb, mis, to);
        exp_rdata = rd;
        checks++;
        if (st != 3 || rq != 1 || a !== 32'h10 || we !== 0 || Mem_R_Data !== exp_rdata) begin
            failures++;
            $display("FAIL b2b_lw: stalls=%0d reqs=%0d addr=%h we=%b rdata=%h, required 3/1/10/0/%h", st, rq, a, we, Mem_R_Data, exp_rdata);
        end
        run_txn(0, 1, 3'b010, 32'h14, 32'h12345678, 0, 0, 0, st, rq, a, w, be, we, stb, mis, to);
        checks++;
        if (st != 2 || rq != 1 || a !== 32'h14 || we !== 1 || w !== 32'h12345678) begin
            failures++;
            $display("FAIL b2b_sw: stalls=%0d reqs=%0d addr=%h we=%b wdata=%h, required 2/1/14/1/12345678", st, rq, a, we, w);
        end
        go_idle();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dmem_req !== 0 || Mem_Stall !== 0) begin
                failures++;
                $display("FAIL b2b_quiet: req=%b stall=%b, required 0/0", dmem_req, Mem_Stall);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int k = 0; k < 40; k++) begin
            int st, rq, gd, rv, mode, e_st;
            logic [31:0] a, w, addr, wd, rd;
            logic [3:0] be;
            logic we, stb, mis, to, e_mis, rdn, wrn;
            logic [2:0] f3;
            mode = $urandom_range(0, 3);
            rdn = mode[0]; wrn = mode[1];
            f3 = f3s[$urandom_range(0, 4)];
            addr = $urandom; wd = $urandom; rd = $urandom;
            gd = $urandom_range(0, 3); rv = $urandom_range(0, 2);
            run_txn(rdn, wrn, f3, addr, wd, gd, rv, rd, st, rq, a, w, be, we, stb, mis, to);
            e_mis = (rdn || wrn) && ref_mis(f3, addr);
            e_st = (!(rdn || wrn) || e_mis) ? 0 : wrn ? 2 + gd : 3 + gd + rv;
            if (rdn && !wrn && !e_mis) exp_rdata = rd >> (8 * (addr % 4));
            checks++;
            if (to || mis !== e_mis || st != e_st || rq != (e_st != 0 ? 1 : 0) || !stb) begin
                failures++;
                $display("FAIL rand_timing[%0d]: mis=%b stalls=%0d reqs=%0d stable=%b, required mis=%b stalls=%0d", k, mis, st, rq, stb, e_mis, e_st);
            end
            if (e_st != 0) begin
                checks++;
                if (a !== (addr & ~32'h3) || be !== ref_be(f3, addr) || we !== wrn || (wrn && w !== ref_wdata(f3, wd))) begin
                    failures++;
                    $display("FAIL rand_fields[%0d]: addr=%h be=%b we=%b wdata=%h, required %h/%b/%b/%h", k, a, be, we, w, addr & ~32'h3, ref_be(f3, addr), wrn, ref_wdata(f3, wd));
                end
            end
            checks++;
            if (Mem_R_Data !== exp_rdata) begin
                failures++;
                $display("FAIL rand_rdata[%0d]: rdata=%h, required %h", k, Mem_R_Data, exp_rdata);
            end
            if ($urandom_range(0, 1)) go_idle();
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        MEM_MemRead = 1; MEM_MemWrite = 0; MEM_Funct3 = 3'b010; MEM_ALU_Result = 32'h500;
        @(negedge clk);
        @(negedge clk);
        dmem_gnt = dmem_req;
        @(negedge clk);
        dmem_gnt = 0;
        checks++;
        if (dmem_req !== 0 || Mem_Stall !== 1) begin
            failures++;
            $display("FAIL mid_wait_entry: req=%b stall=%b, required 0/1", dmem_req, Mem_Stall);
        end
        rst = 1;
        MEM_MemRead = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        dmem_rvalid = 1;
        dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dmem_rvalid = 0;
        checks++;
        if (Mem_R_Data !== 0 || Mem_Stall !== 0 || dmem_req !== 0) begin
            failures++;
            $display("FAIL reset_mid: rdata=%h stall=%b req=%b, required 0/0/0", Mem_R_Data, Mem_Stall, dmem_req);
        end
        exp_rdata = 0;
    endtask

    initial begin
        test_reset();
        test_sw_wait();
        test_sb();
        test_lb();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
